// File: rtl/ioctl_burst_loader.sv
// rtl/ioctl_burst_loader.sv - data_io byte stream to ping-pong word bursts
//
// Assembles ioctl download bytes into DATA_W-bit little-endian words held in
// two BURST-word banks and presents each full (or flushed) bank to a consumer.
// Ports:
//   clk_sys, rst_n                      clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout   data_io download stream
//   out_wr, out_req                     bank presented / consumer pops a word
//   out_addr, out_data                  image word address and current word
//   loaded, overflow                    sticky completion / dropped byte
//   busy                                download running or data still held
module ioctl_burst_loader #(
   parameter int         DATA_W = 16,
   parameter int         BURST  = 64,
   parameter int         ADDR_W = 13,
   parameter logic [7:0] INDEX  = 8'hFF
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              out_wr,
   input  logic              out_req,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              loaded,
   output logic              overflow,
   output logic              busy
);

   localparam int BYTES = DATA_W / 8;
   localparam int SW    = $clog2(BURST);
   localparam int LEN_W = SW + 1;
   localparam int BW    = ADDR_W - SW;
   localparam int BB    = BURST * BYTES;
   localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int MW    = $clog2(2 * BB);

   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(BURST);
   localparam logic [SW-1:0]    SLOT_LAST = SW'(BURST - 1);
   localparam logic [LW-1:0]    LANE_LAST = LW'(BYTES - 1);

   // byte decode
   logic          act;
   logic [24:0]   w_word;
   logic [LW-1:0] w_lane;
   logic [SW-1:0] w_slot;
   logic          w_bank;
   logic [BW-1:0] w_base;
   logic          w_oob;
   logic [MW-1:0] w_mbit;

   assign act    = ioctl_download && (INDEX == 8'hFF || ioctl_index == INDEX);
   assign w_word = ioctl_addr / 25'(BYTES);
   assign w_lane = LW'(ioctl_addr % 25'(BYTES));
   assign w_slot = w_word[SW-1:0];
   // the bank follows the parity of the burst number, so a wrap onto a bank
   // that is still full shows up as an overrun rather than a silent overwrite
   assign w_bank = w_word[SW];
   assign w_base = BW'(w_word >> SW);
   assign w_oob  = (w_word >> ADDR_W) != 25'd0;
   assign w_mbit = MW'({w_bank, w_slot}) * MW'(BYTES) + MW'(w_lane);

   // state
   logic                  act_q, act_qq;
   logic                  run_q, run_d;
   logic                  loaded_q, loaded_d;
   logic                  overflow_q, overflow_d;
   logic                  wb_q, wb_d;
   logic                  rb_q, rb_d;
   logic [SW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [1:0]            full_q, full_d;
   logic [1:0]            written_q, written_d;
   logic [1:0][LEN_W-1:0] len_q, len_d;
   logic [1:0][BW-1:0]    base_q, base_d;
   logic [1:0][SW-1:0]    hi_q, hi_d;
   // one bit per byte: bytes never written since the bank was freed read as 0
   logic [2*BB-1:0]       mask_q, mask_d;
   logic [DATA_W-1:0]     mem_q [2*BURST];

   logic start, fall, wr_ok;

   // edges are taken from the registered compare
   assign start = act_q && !act_qq;
   assign fall  = !act_q && act_qq;

   always_comb begin
      run_d      = run_q;
      loaded_d   = loaded_q;
      overflow_d = overflow_q;
      wb_d       = wb_q;
      rb_d       = rb_q;
      rd_ptr_d   = rd_ptr_q;
      full_d     = full_q;
      written_d  = written_q;
      len_d      = len_q;
      base_d     = base_q;
      hi_d       = hi_q;
      mask_d     = mask_q;
      wr_ok      = 1'b0;
      if (start) begin
         run_d      = 1'b1;
         loaded_d   = 1'b0;
         overflow_d = 1'b0;
         wb_d       = 1'b0;
         rb_d       = 1'b0;
         rd_ptr_d   = '0;
         full_d     = '0;
         written_d  = '0;
         mask_d     = '0;
      end else begin
         if (out_req && full_q[rb_q]) begin
            if ({1'b0, rd_ptr_q} == len_q[rb_q] - LEN_ONE) begin
               full_d[rb_q]    = 1'b0;
               written_d[rb_q] = 1'b0;
               if (rb_q) mask_d[2*BB-1:BB] = '0;
               else      mask_d[BB-1:0]    = '0;
               rd_ptr_d = '0;
               rb_d     = !rb_q;
            end else begin
               rd_ptr_d = rd_ptr_q + SW'(1);
            end
         end
         // full_q (not full_d): a bank being freed this cycle still rejects
         if (ioctl_wr && act) begin
            if (w_oob || full_q[w_bank]) begin
               overflow_d = 1'b1;
            end else begin
               wr_ok = 1'b1;
               if (!written_q[w_bank]) begin
                  base_d[w_bank] = w_base;
                  hi_d[w_bank]   = w_slot;
               end else if (w_slot > hi_q[w_bank]) begin
                  hi_d[w_bank] = w_slot;
               end
               written_d[w_bank] = 1'b1;
               mask_d[w_mbit]    = 1'b1;
               wb_d              = w_bank;
               if (w_slot == SLOT_LAST && w_lane == LANE_LAST) begin
                  full_d[w_bank] = 1'b1;
                  len_d[w_bank]  = LEN_FULL;
                  wb_d           = !w_bank;
               end
            end
         end
         if (fall && written_d[wb_d] && !full_d[wb_d]) begin
            full_d[wb_d] = 1'b1;
            len_d[wb_d]  = {1'b0, hi_d[wb_d]} + LEN_ONE;
         end
         if (run_q && !act_q && full_d == 2'b00 && written_d == 2'b00) begin
            loaded_d = 1'b1;
            run_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         act_q      <= 1'b0;
         act_qq     <= 1'b0;
         run_q      <= 1'b0;
         loaded_q   <= 1'b0;
         overflow_q <= 1'b0;
         wb_q       <= 1'b0;
         rb_q       <= 1'b0;
         rd_ptr_q   <= '0;
         full_q     <= '0;
         written_q  <= '0;
         len_q      <= '0;
         base_q     <= '0;
         hi_q       <= '0;
         mask_q     <= '0;
      end else begin
         act_q      <= act;
         act_qq     <= act_q;
         run_q      <= run_d;
         loaded_q   <= loaded_d;
         overflow_q <= overflow_d;
         wb_q       <= wb_d;
         rb_q       <= rb_d;
         rd_ptr_q   <= rd_ptr_d;
         full_q     <= full_d;
         written_q  <= written_d;
         len_q      <= len_d;
         base_q     <= base_d;
         hi_q       <= hi_d;
         mask_q     <= mask_d;
      end
   end

   // word storage needs no reset; validity lives in mask_q
   always_ff @(posedge clk_sys) begin
      for (int k = 0; k < BYTES; k++) begin
         if (wr_ok && w_lane == LW'(k)) mem_q[{w_bank, w_slot}][8*k +: 8] <= ioctl_dout;
      end
   end

   logic [DATA_W-1:0] rd_word;
   logic [MW-1:0]     rd_mbase;

   assign rd_word  = mem_q[{rb_q, rd_ptr_q}];
   assign rd_mbase = MW'({rb_q, rd_ptr_q}) * MW'(BYTES);

   assign out_wr   = full_q[rb_q];
   assign out_addr = out_wr ? {base_q[rb_q], rd_ptr_q} : '0;

   always_comb begin
      out_data = '0;
      for (int k = 0; k < BYTES; k++) begin
         if (out_wr && mask_q[rd_mbase + MW'(k)]) out_data[8*k +: 8] = rd_word[8*k +: 8];
      end
   end

   assign loaded   = loaded_q;
   assign overflow = overflow_q;
   assign busy     = run_q || (full_q != 2'b00) || (written_q != 2'b00);

endmodule
